// File: rtl/jtag_dr_bank.sv
// JTAG data-register bank: BYPASS, IDCODE and NUM_USER_DR user DRs sharing one shift register.
// Optional shift-length checking on user-DR updates is enabled by defining JTAG_DR_LEN_CHECK_EN.
package jtag_dr_bank_pkg;
  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'd0,
    RUN_TEST_IDLE    = 4'd1,
    SELECT_DR_SCAN   = 4'd2,
    CAPTURE_DR       = 4'd3,
    SHIFT_DR         = 4'd4,
    EXIT1_DR         = 4'd5,
    PAUSE_DR         = 4'd6,
    EXIT2_DR         = 4'd7,
    UPDATE_DR        = 4'd8,
    SELECT_IR_SCAN   = 4'd9,
    CAPTURE_IR       = 4'd10,
    SHIFT_IR         = 4'd11,
    EXIT1_IR         = 4'd12,
    PAUSE_IR         = 4'd13,
    EXIT2_IR         = 4'd14,
    UPDATE_IR        = 4'd15
  } tap_ctrl_fsm_t;
endpackage

module jtag_dr_bank
  import jtag_dr_bank_pkg::*;
#(
  parameter int                     DR_WIDTH    = 32,
  parameter int                     NUM_USER_DR = 4,
  parameter logic [31:0]            IDCODE_VAL  = 32'h10F,
  parameter logic [NUM_USER_DR-1:0] RO_MASK     = 4'b0100,
  parameter int                     SEL_W       = 4
) (
  input  logic                            i_tck,
  input  logic                            i_trstn,
  input  logic                            i_tdi,
  output logic                            o_tdo,
  output logic                            o_tdo_en,
  input  tap_ctrl_fsm_t                   i_tap_state,
  input  logic [SEL_W-1:0]                i_dr_sel,
  input  logic [NUM_USER_DR*DR_WIDTH-1:0] i_cap_data,
  output logic [NUM_USER_DR*DR_WIDTH-1:0] o_upd_data,
  output logic [NUM_USER_DR-1:0]          o_upd_valid,
  output logic                            o_len_err
);

  localparam int CNT_W = $clog2(DR_WIDTH + 2);

  logic [DR_WIDTH-1:0]             r_sr;
  logic                            r_bypass;
  logic [CNT_W-1:0]                r_cnt;
  logic [NUM_USER_DR-1:0]          w_sel_user;
  logic                            w_sel_idcode;
  logic                            w_sel_bypass;
  logic [DR_WIDTH-1:0]             w_cap_val;
  logic [NUM_USER_DR*DR_WIDTH-1:0] w_upd_data;
  logic                            w_update;
  logic                            w_upd_ok;

  // Out-of-range selections fall through to BYPASS.
  assign w_sel_idcode = (i_dr_sel == SEL_W'(1));
  assign w_sel_bypass = !w_sel_idcode && !(|w_sel_user);
  assign w_update     = (i_tap_state == UPDATE_DR);

  assign o_tdo_en = (i_tap_state == SHIFT_DR);
  assign o_tdo    = o_tdo_en ? (w_sel_bypass ? r_bypass : r_sr[0]) : 1'b0;

  always_comb begin
    w_cap_val = '0;
    if (w_sel_idcode) w_cap_val = DR_WIDTH'(IDCODE_VAL);
    for (int i = 0; i < NUM_USER_DR; i++) begin
      if (w_sel_user[i])
        w_cap_val = RO_MASK[i] ? i_cap_data[i*DR_WIDTH +: DR_WIDTH]
                               : w_upd_data[i*DR_WIDTH +: DR_WIDTH];
    end
  end

  always_ff @(posedge i_tck or negedge i_trstn) begin
    if (!i_trstn) begin
      r_sr     <= '0;
      r_bypass <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (i_tap_state)
        TEST_LOGIC_RESET: begin
          r_sr  <= '0;
          r_cnt <= '0;
        end
        CAPTURE_DR: begin
          if (w_sel_bypass) r_bypass <= 1'b0;
          else              r_sr     <= w_cap_val;
          r_cnt <= '0;
        end
        SHIFT_DR: begin
          if (w_sel_bypass)      r_bypass <= i_tdi;
          else if (w_sel_idcode) r_sr     <= {r_sr[0], r_sr[DR_WIDTH-1:1]};
          else                   r_sr     <= {i_tdi, r_sr[DR_WIDTH-1:1]};
          // Saturate one past a full-length scan so over-long scans stay detectable.
          if (r_cnt != CNT_W'(DR_WIDTH + 1)) r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef JTAG_DR_LEN_CHECK_EN
  logic w_sel_rw;
  logic r_len_err;

  assign w_sel_rw  = |(w_sel_user & ~RO_MASK);
  assign w_upd_ok  = (r_cnt == CNT_W'(DR_WIDTH));
  assign o_len_err = r_len_err;

  always_ff @(posedge i_tck or negedge i_trstn) begin
    if (!i_trstn)                 r_len_err <= 1'b0;
    else if (w_update && w_sel_rw) r_len_err <= !w_upd_ok;
  end
`else
  assign w_upd_ok  = 1'b1;
  assign o_len_err = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < NUM_USER_DR; gi++) begin : g_dr
      assign w_sel_user[gi] = (i_dr_sel == SEL_W'(gi + 2));

      if (RO_MASK[gi]) begin : g_ro
        assign w_upd_data[gi*DR_WIDTH +: DR_WIDTH] = '0;
        assign o_upd_valid[gi]                     = 1'b0;
      end else begin : g_rw
        logic [DR_WIDTH-1:0] r_hold;
        logic                r_valid;

        always_ff @(posedge i_tck or negedge i_trstn) begin
          if (!i_trstn) begin
            r_hold  <= '0;
            r_valid <= 1'b0;
          end else begin
            r_valid <= 1'b0;
            if (w_update && w_sel_user[gi] && w_upd_ok) begin
              r_hold  <= r_sr;
              r_valid <= 1'b1;
            end
          end
        end

        assign w_upd_data[gi*DR_WIDTH +: DR_WIDTH] = r_hold;
        assign o_upd_valid[gi]                     = r_valid;
      end
    end
  endgenerate

  assign o_upd_data = w_upd_data;

endmodule

// File: tb/tb_jtag_dr_bank.sv
// Scoreboard bench for jtag_dr_bank: directed scans push expected tdo bits and update strobes;
// a negedge monitor pops and compares whenever the DUT shifts or strobes.
module tb_jtag_dr_bank;
  import jtag_dr_bank_pkg::*;

  localparam int W = 32;
  localparam int N = 4;

  typedef struct {
    int           idx;
    logic [W-1:0] data;
  } upd_t;

  logic          tck = 1'b0;
  logic          trstn = 1'b0;
  logic          tdi = 1'b0;
  tap_ctrl_fsm_t st = TEST_LOGIC_RESET;
  logic [3:0]    sel = 4'd0;
  logic [N*W-1:0] cap = '0;
  logic          o_tdo, o_tdo_en, o_len_err;
  logic [N*W-1:0] o_upd_data;
  logic [N-1:0]  o_upd_valid;

  int errors = 0;
  int checks = 0;
  bit   exp_tdo_q[$];
  upd_t exp_upd_q[$];
  logic [W-1:0] prev_val;

  jtag_dr_bank dut (
    .i_tck(tck), .i_trstn(trstn), .i_tdi(tdi), .o_tdo(o_tdo), .o_tdo_en(o_tdo_en),
    .i_tap_state(st), .i_dr_sel(sel), .i_cap_data(cap), .o_upd_data(o_upd_data),
    .o_upd_valid(o_upd_valid), .o_len_err(o_len_err)
  );

  always #5 tck = ~tck;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic step(input tap_ctrl_fsm_t s, input logic d);
    st = s;
    tdi = d;
    @(posedge tck);
    #1;
  endtask

  task automatic shift_word(input logic [W-1:0] din, input logic [W-1:0] exp_out, input int n);
    for (int i = 0; i < n; i++) begin
      exp_tdo_q.push_back(exp_out[i]);
      step(SHIFT_DR, din[i]);
    end
  endtask

  task automatic scan(input logic [3:0] s, input logic [W-1:0] din, input logic [W-1:0] exp_out,
                      input int n, input bit expect_upd, input int idx, input logic [W-1:0] upd_val);
    upd_t u;
    sel = s;
    step(CAPTURE_DR, 1'b0);
    shift_word(din, exp_out, n);
    step(EXIT1_DR, 1'b0);
    if (expect_upd) begin
      u.idx = idx;
      u.data = upd_val;
      exp_upd_q.push_back(u);
    end
    step(UPDATE_DR, 1'b0);
    step(RUN_TEST_IDLE, 1'b0);
    step(RUN_TEST_IDLE, 1'b0);
  endtask

  // Monitor: every shifted bit and every update strobe must match the head of its queue.
  always @(negedge tck) begin : monitor
    bit   e;
    upd_t u;
    if (trstn) begin
      if (o_tdo_en) begin
        checks++;
        if (exp_tdo_q.size() == 0) begin
          errors++;
          $display("FAIL tdo_unexpected: got %b want no shift", o_tdo);
        end else begin
          e = exp_tdo_q.pop_front();
          if (o_tdo !== e) begin
            errors++;
            $display("FAIL tdo_bit sel=%0d: got %b want %b", sel, o_tdo, e);
          end
        end
      end
      if (o_upd_valid !== '0) begin
        checks++;
        if (exp_upd_q.size() == 0) begin
          errors++;
          $display("FAIL upd_spurious: got upd_valid=%b want 0", o_upd_valid);
        end else begin
          u = exp_upd_q.pop_front();
          if (o_upd_valid !== N'(1 << u.idx) || o_upd_data[u.idx*W +: W] !== u.data) begin
            errors++;
            $display("FAIL upd_strobe: got valid=%b data=%h want valid=%b data=%h",
                     o_upd_valid, o_upd_data[u.idx*W +: W], N'(1 << u.idx), u.data);
          end
        end
      end
    end
  end

  initial begin
    cap[2*W +: W] = 32'hCAFE0001;
    repeat (2) @(posedge tck);
    #1;
    for (int i = 0; i < N; i++) chk($sformatf("rst_upd_data%0d", i), o_upd_data[i*W +: W], '0);
    chk("rst_upd_valid", W'(o_upd_valid), '0);
    chk("rst_len_err", W'(o_len_err), '0);
    chk("rst_tdo", W'(o_tdo), '0);
    trstn = 1'b1;
    step(RUN_TEST_IDLE, 1'b0);

    // IDCODE rotates, survives a pause, and never strobes.
    sel = 4'd1;
    step(CAPTURE_DR, 1'b0);
    shift_word('0, 32'h0000010F, 32);
    step(EXIT1_DR, 1'b0);
    repeat (3) step(PAUSE_DR, 1'b0);
    step(EXIT2_DR, 1'b0);
    shift_word('0, 32'h0000010F, 32);
    step(EXIT1_DR, 1'b0);
    step(UPDATE_DR, 1'b0);
    step(RUN_TEST_IDLE, 1'b0);
    chk("tdo_idle", W'(o_tdo), '0);

    // BYPASS: tdi 1,0,1,1,0,0,1,1 emerges one cycle late behind a 0.
    scan(4'd0, 32'h000000CD, 32'h0000009A, 8, 1'b0, 0, '0);

    // RW DR 0: load, then recapture shows the loaded value.
    scan(4'd2, 32'hDEADBEEF, 32'h00000000, 32, 1'b1, 0, 32'hDEADBEEF);
    chk("rw0_hold", o_upd_data[0 +: W], 32'hDEADBEEF);
    scan(4'd2, 32'hDEADBEEF, 32'hDEADBEEF, 32, 1'b1, 0, 32'hDEADBEEF);

    // RO DR 2: captures cap_data, never strobes, holding stays 0.
    scan(4'd4, 32'h00000000, 32'hCAFE0001, 32, 1'b0, 0, '0);
    chk("ro2_hold", o_upd_data[2*W +: W], '0);

    // Truncated scan on DR 1, then a full-length retry.
`ifdef JTAG_DR_LEN_CHECK_EN
    scan(4'd3, 32'h00001234, 32'h00000000, 31, 1'b0, 1, '0);
    chk("len_err_set", W'(o_len_err), 32'd1);
    prev_val = 32'h00000000;
`else
    scan(4'd3, 32'h00001234, 32'h00000000, 31, 1'b1, 1, 32'h00002468);
    chk("len_err_tied", W'(o_len_err), '0);
    prev_val = 32'h00002468;
`endif
    scan(4'd3, 32'h00001234, prev_val, 32, 1'b1, 1, 32'h00001234);
    chk("len_err_clear", W'(o_len_err), '0);
    chk("rw1_hold", o_upd_data[1*W +: W], 32'h00001234);

    // Out-of-range select behaves as BYPASS.
    scan(4'd15, 32'h00000003, 32'h00000002, 2, 1'b0, 0, '0);

    // Test-Logic-Reset clears the shift register but not the holding registers.
    sel = 4'd1;
    step(CAPTURE_DR, 1'b0);
    shift_word('0, 32'h0000010F, 5);
    step(TEST_LOGIC_RESET, 1'b0);
    shift_word('0, 32'h00000000, 4);
    step(EXIT1_DR, 1'b0);
    step(UPDATE_DR, 1'b0);
    step(RUN_TEST_IDLE, 1'b0);
    chk("tlr_keeps_hold", o_upd_data[0 +: W], 32'hDEADBEEF);

    // Reset in the middle of a DR 0 scan.
    sel = 4'd2;
    step(CAPTURE_DR, 1'b0);
    shift_word('0, 32'hDEADBEEF, 10);
    #2 trstn = 1'b0;
    #1;
    chk("midrst_tdo", W'(o_tdo), '0);
    chk("midrst_hold", o_upd_data[0 +: W], '0);
    chk("midrst_valid", W'(o_upd_valid), '0);
    step(UPDATE_DR, 1'b0);
    step(TEST_LOGIC_RESET, 1'b0);
    trstn = 1'b1;
    step(RUN_TEST_IDLE, 1'b0);
    step(RUN_TEST_IDLE, 1'b0);
    chk("postrst_hold", o_upd_data[0 +: W], '0);
    chk("postrst_valid", W'(o_upd_valid), '0);

    chk("tdo_q_drained", W'(exp_tdo_q.size()), '0);
    chk("upd_q_drained", W'(exp_upd_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
